uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Serial receive stage that sits directly downstream of the APB UART transmitter in the UART test bench. It samples the transmitter's TXD line, deframes 8N1 characters (LSB first) and presents each byte on a valid/ready handshake. The bench uses it as a self-checking byte scoreboard source. It also flags false starts, framing errors and overruns, and counts received bytes.

## Interface
Parameters:
- CNT_W, 20, width of the bit-period counter and of BAUDDIV.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  receiver enable; low forces IDLE.
- BAUDDIV  in  CNT_W  bit period in CLK cycles; legal range is ≥16; sampled only in IDLE.
- RXD  in  1  serial input, asynchronous; connected to the transmitter's TXD.
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  RX_DATA holds an unconsumed byte.
- RX_READY  in  1  consumer accepts the byte when RX_VALID & RX_READY.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: a new byte was completed while RX_VALID was still high.
- RX_COUNT  out  16  count of bytes accepted into RX_DATA; wraps 0xFFFF→0x0000.

## Operation
- RXD passes through a 2-flop synchronizer (reset value 1) to give rxd_s. An edge detector uses one more flop.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a falling edge of rxd_s with ENABLE high does three things:
  - latches BAUDDIV into bdiv;
  - loads cnt with floor(bdiv/2)-1;
  - moves to START.
- cnt decrements every cycle. A "sample" occurs in the cycle where cnt==0; on each sample cnt reloads with bdiv-1.
- START sample:
  - rxd_s=1 means a false start: go to IDLE, no outputs.
  - rxd_s=0: clear bit index, go to DATA.
- DATA sample: shift rxd_s into the shift register MSB (a right-shift, so LSB-first on the line). After 8 samples go to STOP.
- STOP sample, stop bit = 1:
  - if RX_VALID=0 or RX_READY=1 in that cycle: load RX_DATA, set RX_VALID, increment RX_COUNT.
  - else discard the byte and pulse OVERRUN; RX_DATA and RX_COUNT are unchanged.
  - go to IDLE.
- STOP sample, stop bit = 0:
  - pulse FRAME_ERR; the byte is discarded.
  - go to WAIT_HIGH, which stays until rxd_s=1 and then goes to IDLE. This prevents a break condition from retriggering.
- Handshake:
  - RX_VALID clears on the cycle after RX_VALID & RX_READY, unless the same cycle loads a new byte, in which case RX_VALID stays high with the new data.
  - RX_DATA is stable while RX_VALID=1.
- ENABLE low in any state: next state is IDLE, the partial frame is dropped, RX_VALID and RX_DATA are untouched.
- Changes to BAUDDIV mid-frame have no effect until the next IDLE.

## Timing
- Reset values:
  - RX_DATA=0x00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, RX_COUNT=0.
  - state=IDLE, synchronizer flops=1.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs at reset values.
- Let a RXD falling edge be registered at cycle T:
  - the edge is detected at T+2 and START is entered at T+3;
  - the start sample is at T+2+floor(bdiv/2);
  - data bit k is sampled at T+2+floor(bdiv/2)+(k+1)·bdiv;
  - the stop bit is sampled at T+2+floor(bdiv/2)+9·bdiv.
- RX_VALID, FRAME_ERR, OVERRUN and the RX_COUNT update are all visible the cycle after the stop sample.
- A start bit arriving exactly one bdiv after the stop-bit centre (back-to-back frames) must be caught: IDLE is reached before the next falling edge.
- A glitch low shorter than floor(bdiv/2) cycles is a false start.
- FRAME_ERR and OVERRUN are mutually exclusive and each lasts exactly one cycle.

## Test plan
- BAUDDIV=16, ENABLE=1, RX_READY=1, the transmitter sends 0x55 → RX_VALID high for 1 cycle with RX_DATA=0x55, RX_COUNT=1, no error pulses.
- BAUDDIV=16, back-to-back frames 0xA3 then 0x0F → two accepts with RX_DATA 0xA3 then 0x0F, RX_COUNT=2.
- RXD low for 4 cycles then high, BAUDDIV=32 → no RX_VALID, state returns to IDLE, RX_COUNT unchanged.
- Frame 0x81 with stop bit driven 0, line held low 40 cycles → one FRAME_ERR pulse, no RX_VALID, no new frame until RXD returns high.
- RX_READY=0, send 0x11 then 0x22 → RX_DATA stays 0x11, one OVERRUN pulse at the second stop sample, RX_COUNT=1; raising RX_READY clears RX_VALID the next cycle.
- RESET during bit 4 of 0x3C, then send 0xC3 → all outputs at reset values after reset, then RX_DATA=0xC3 with RX_COUNT=1.

Source files
------------

// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_monitor
// Description : 8N1 serial receiver with valid/ready byte output, false-start,
//               framing-error and overrun detection, and a received-byte count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_monitor #(
    parameter int CNT_W = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [CNT_W-1:0] BAUDDIV,
    input  logic             RXD,
    output logic [7:0]       RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic [15:0]      RX_COUNT
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_stop      = 3'd3;
    localparam logic [2:0] c_st_wait_high = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_sync1;
    logic             r_rxd_s;
    logic             r_rxd_prev;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_bdiv;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic w_fall;
    logic w_sample;
    logic w_accept;
    logic w_room;
    logic w_counting;

    assign w_fall     = r_rxd_prev & ~r_rxd_s;
    assign w_sample   = (r_cnt == '0);
    assign w_accept   = RX_VALID & RX_READY;
    assign w_room     = ~RX_VALID | RX_READY;
    assign w_counting = (r_state == c_st_start) | (r_state == c_st_data) |
                        (r_state == c_st_stop);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_state    <= c_st_idle;
            r_bdiv     <= '0;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            RX_DATA    <= 8'h00;
            RX_VALID   <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
            RX_COUNT   <= 16'h0000;
        end else begin
            r_sync1    <= RXD;
            r_rxd_s    <= r_sync1;
            r_rxd_prev <= r_rxd_s;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;

            // A load later in this block overrides this clear.
            if (w_accept) begin
                RX_VALID <= 1'b0;
            end

            if (w_counting) begin
                r_cnt <= w_sample ? (r_bdiv - c_cnt_one) : (r_cnt - c_cnt_one);
            end

            if (!ENABLE) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_fall) begin
                            r_bdiv  <= BAUDDIV;
                            r_cnt   <= (BAUDDIV >> 1) - c_cnt_one;
                            r_state <= c_st_start;
                        end
                    end
                    c_st_start: begin
                        if (w_sample) begin
                            if (r_rxd_s) begin
                                r_state <= c_st_idle;
                            end else begin
                                r_bit_idx <= 3'd0;
                                r_state   <= c_st_data;
                            end
                        end
                    end
                    c_st_data: begin
                        if (w_sample) begin
                            r_shift   <= {r_rxd_s, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= c_st_stop;
                            end
                        end
                    end
                    c_st_stop: begin
                        if (w_sample) begin
                            if (r_rxd_s) begin
                                if (w_room) begin
                                    RX_DATA  <= r_shift;
                                    RX_VALID <= 1'b1;
                                    RX_COUNT <= RX_COUNT + 16'd1;
                                end else begin
                                    OVERRUN <= 1'b1;
                                end
                                r_state <= c_st_idle;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                r_state   <= c_st_wait_high;
                            end
                        end
                    end
                    // Hold off during a break so a low line cannot retrigger.
                    c_st_wait_high: begin
                        if (r_rxd_s) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_monitor
// Description : Self-checking bench for uart_rx_monitor with a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_monitor;

    localparam int CNT_W = 20;

    logic             CLK;
    logic             RESET;
    logic             ENABLE;
    logic [CNT_W-1:0] BAUDDIV;
    logic             RXD;
    logic [7:0]       RX_DATA;
    logic             RX_VALID;
    logic             RX_READY;
    logic             FRAME_ERR;
    logic             OVERRUN;
    logic [15:0]      RX_COUNT;

    uart_rx_monitor #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .BAUDDIV   (BAUDDIV),
        .RXD       (RXD),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .RX_COUNT  (RX_COUNT)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_count = 0;

    int valid_rises, valid_cycles, last_valid_cyc;
    int fe_cnt, fe_long, last_fe_cyc;
    int ov_cnt, ov_long, last_ov_cyc;
    int both_cnt;
    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;
    logic prev_ov    = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Output collector: observes handshakes and error pulses mid-cycle.
    always @(negedge CLK) begin
        if (RX_VALID && RX_READY) got_q.push_back(RX_DATA);
        if (RX_VALID && !prev_valid) begin
            valid_rises++;
            last_valid_cyc = cyc;
        end
        if (RX_VALID) valid_cycles++;
        if (FRAME_ERR) begin
            fe_cnt++;
            last_fe_cyc = cyc;
            if (prev_fe) fe_long++;
        end
        if (OVERRUN) begin
            ov_cnt++;
            last_ov_cyc = cyc;
            if (prev_ov) ov_long++;
        end
        if (FRAME_ERR && OVERRUN) both_cnt++;
        prev_valid = RX_VALID;
        prev_fe    = FRAME_ERR;
        prev_ov    = OVERRUN;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        valid_rises = 0; valid_cycles = 0; last_valid_cyc = -1;
        fe_cnt = 0; fe_long = 0; last_fe_cyc = -1;
        ov_cnt = 0; ov_long = 0; last_ov_cyc = -1;
        both_cnt = 0;
        got_q.delete();
    endtask

    // Drives start, data LSB first, stop; nbits<10 truncates the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int b,
                              input int nbits, output int start_cyc);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            RXD = bits[i];
            tick(b);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
        tick(2);
        tests_run++; if (RX_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h expected 00", RX_DATA); end
        tests_run++; if (RX_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", RX_VALID); end
        tests_run++; if (FRAME_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %0b expected 0", FRAME_ERR); end
        tests_run++; if (OVERRUN !== 1'b0) begin tests_failed++; $display("FAIL reset_ov: got %0b expected 0", OVERRUN); end
        tests_run++; if (RX_COUNT !== 16'h0) begin tests_failed++; $display("FAIL reset_count: got %0h expected 0", RX_COUNT); end
    endtask

    task automatic test_single();
        int s;
        clear_mon();
        BAUDDIV = 16;
        exp_q.push_back(8'h55); exp_count++;
        send_frame(8'h55, 1'b1, 16, 10, s);
        tick(4);
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL single_data: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL single_data: got %0h expected %0h", g, e); end end
        end
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL single_extra: got %0d extra bytes expected 0", got_q.size()); end
        tests_run++; if (valid_cycles != 1) begin tests_failed++; $display("FAIL single_valid_width: got %0d expected 1", valid_cycles); end
        tests_run++; if (last_valid_cyc != s + 3 + 8 + 9*16) begin tests_failed++; $display("FAIL single_valid_time: got %0d expected %0d", last_valid_cyc, s + 3 + 8 + 9*16); end
        tests_run++; if (RX_COUNT !== 16'(exp_count)) begin tests_failed++; $display("FAIL single_count: got %0d expected %0d", RX_COUNT, exp_count); end
        tests_run++; if (fe_cnt + ov_cnt != 0) begin tests_failed++; $display("FAIL single_errs: got %0d expected 0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_back_to_back();
        int s;
        clear_mon();
        exp_q.push_back(8'hA3); exp_count++;
        exp_q.push_back(8'h0F); exp_count++;
        send_frame(8'hA3, 1'b1, 16, 10, s);
        send_frame(8'h0F, 1'b1, 16, 10, s);
        tick(4);
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL b2b_data: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL b2b_data: got %0h expected %0h", g, e); end end
        end
        tests_run++; if (valid_rises != 2) begin tests_failed++; $display("FAIL b2b_accepts: got %0d expected 2", valid_rises); end
        tests_run++; if (RX_COUNT !== 16'(exp_count)) begin tests_failed++; $display("FAIL b2b_count: got %0d expected %0d", RX_COUNT, exp_count); end
        tests_run++; if (fe_cnt + ov_cnt != 0) begin tests_failed++; $display("FAIL b2b_errs: got %0d expected 0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_false_start();
        int s;
        clear_mon();
        BAUDDIV = 32;
        RXD = 1'b0;
        tick(4);
        RXD = 1'b1;
        tick(60);
        tests_run++; if (valid_rises != 0) begin tests_failed++; $display("FAIL glitch_valid: got %0d expected 0", valid_rises); end
        tests_run++; if (RX_COUNT !== 16'(exp_count)) begin tests_failed++; $display("FAIL glitch_count: got %0d expected %0d", RX_COUNT, exp_count); end
        tests_run++; if (fe_cnt + ov_cnt != 0) begin tests_failed++; $display("FAIL glitch_errs: got %0d expected 0", fe_cnt + ov_cnt); end
        exp_q.push_back(8'h5A); exp_count++;
        send_frame(8'h5A, 1'b1, 32, 10, s);
        tick(4);
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL glitch_next_data: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL glitch_next_data: got %0h expected %0h", g, e); end end
        end
        tests_run++; if (last_valid_cyc != s + 3 + 16 + 9*32) begin tests_failed++; $display("FAIL glitch_next_time: got %0d expected %0d", last_valid_cyc, s + 3 + 16 + 9*32); end
        BAUDDIV = 16;
    endtask

    task automatic test_frame_err();
        int s;
        int cnt0;
        clear_mon();
        cnt0 = exp_count;
        send_frame(8'h81, 1'b0, 16, 10, s);
        tick(40);
        RXD = 1'b1;
        tick(20);
        tests_run++; if (fe_cnt != 1) begin tests_failed++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt); end
        tests_run++; if (fe_long != 0) begin tests_failed++; $display("FAIL ferr_width: got %0d long expected 0", fe_long); end
        tests_run++; if (last_fe_cyc != s + 3 + 8 + 9*16) begin tests_failed++; $display("FAIL ferr_time: got %0d expected %0d", last_fe_cyc, s + 3 + 8 + 9*16); end
        tests_run++; if (valid_rises != 0) begin tests_failed++; $display("FAIL ferr_valid: got %0d expected 0", valid_rises); end
        tests_run++; if (ov_cnt != 0) begin tests_failed++; $display("FAIL ferr_ov: got %0d expected 0", ov_cnt); end
        tests_run++; if (RX_COUNT !== 16'(cnt0)) begin tests_failed++; $display("FAIL ferr_count: got %0d expected %0d", RX_COUNT, cnt0); end
        exp_q.push_back(8'h42); exp_count++;
        send_frame(8'h42, 1'b1, 16, 10, s);
        tick(4);
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL ferr_recover: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL ferr_recover: got %0h expected %0h", g, e); end end
        end
    endtask

    task automatic test_overrun();
        int s1, s2;
        clear_mon();
        RX_READY = 1'b0;
        exp_q.push_back(8'h11); exp_count++;
        send_frame(8'h11, 1'b1, 16, 10, s1);
        send_frame(8'h22, 1'b1, 16, 10, s2);
        tick(4);
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL ovr_early_accept: got %0d expected 0", got_q.size()); end
        tests_run++; if (RX_VALID !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %0b expected 1", RX_VALID); end
        tests_run++; if (RX_DATA !== 8'h11) begin tests_failed++; $display("FAIL ovr_data: got %0h expected 11", RX_DATA); end
        tests_run++; if (ov_cnt != 1 || ov_long != 0) begin tests_failed++; $display("FAIL ovr_pulses: got %0d/%0d expected 1/0", ov_cnt, ov_long); end
        tests_run++; if (last_ov_cyc != s2 + 3 + 8 + 9*16) begin tests_failed++; $display("FAIL ovr_time: got %0d expected %0d", last_ov_cyc, s2 + 3 + 8 + 9*16); end
        tests_run++; if (fe_cnt != 0 || both_cnt != 0) begin tests_failed++; $display("FAIL ovr_fe: got %0d expected 0", fe_cnt + both_cnt); end
        tests_run++; if (RX_COUNT !== 16'(exp_count)) begin tests_failed++; $display("FAIL ovr_count: got %0d expected %0d", RX_COUNT, exp_count); end
        RX_READY = 1'b1;
        tick(1);
        tests_run++; if (RX_VALID !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %0b expected 0", RX_VALID); end
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL ovr_accept: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL ovr_accept: got %0h expected %0h", g, e); end end
        end
        tick(4);
    endtask

    task automatic test_reset_midframe();
        int s;
        clear_mon();
        send_frame(8'h3C, 1'b1, 16, 5, s);
        RXD = 1'b1;
        tick(8);
        RESET = 1'b1;
        tick(1);
        tests_run++; if (RX_DATA !== 8'h00) begin tests_failed++; $display("FAIL midrst_data: got %0h expected 00", RX_DATA); end
        tests_run++; if (RX_VALID !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %0b expected 0", RX_VALID); end
        tests_run++; if (RX_COUNT !== 16'h0) begin tests_failed++; $display("FAIL midrst_count: got %0h expected 0", RX_COUNT); end
        tests_run++; if (FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0) begin tests_failed++; $display("FAIL midrst_errs: got %0b%0b expected 00", FRAME_ERR, OVERRUN); end
        RESET = 1'b0;
        exp_count = 0;
        exp_q.delete();
        tick(30);
        clear_mon();
        exp_q.push_back(8'hC3); exp_count++;
        send_frame(8'hC3, 1'b1, 16, 10, s);
        tick(4);
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("FAIL midrst_next: got none expected %0h", e); end
            else begin logic [7:0] g = got_q.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL midrst_next: got %0h expected %0h", g, e); end end
        end
        tests_run++; if (RX_COUNT !== 16'(exp_count)) begin tests_failed++; $display("FAIL midrst_next_count: got %0d expected %0d", RX_COUNT, exp_count); end
        tests_run++; if (valid_rises != 1) begin tests_failed++; $display("FAIL midrst_garbage: got %0d frames expected 1", valid_rises); end
    endtask

    initial begin
        RESET    = 1'b1;
        ENABLE   = 1'b1;
        BAUDDIV  = 16;
        RXD      = 1'b1;
        RX_READY = 1'b1;
        clear_mon();
        @(posedge CLK);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
